// File: rtl/cgra_pkg.sv
// cgra_pkg: shared types and default sizes for the tile's adder sequencing logic.
package cgra_pkg;
   localparam int ADD_WIDTH = 16;
   localparam int ADD_CHUNKS = 4;
   typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, RESP} state_t;
endpackage

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: splits a wide add into WIDTH-bit chunks on an external registered adder, carry chained LSB first.
// Optional WIDE_ADD_ACK_CHECK_EN adds a sticky err output raised when the adder fails to ack a chunk.
module wide_add_sequencer
   import cgra_pkg::*;
#(
   parameter int WIDTH = ADD_WIDTH,
   parameter int CHUNKS = ADD_CHUNKS
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [WIDTH*CHUNKS-1:0]  req_a,
   input  logic [WIDTH*CHUNKS-1:0]  req_b,
   input  logic                     req_cin,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [WIDTH*CHUNKS-1:0]  resp_sum,
   output logic                     resp_cout,
   output logic [WIDTH-1:0]         add_a,
   output logic [WIDTH-1:0]         add_b,
   output logic                     add_carry_in,
   output logic                     add_carry_listen,
   output logic                     add_on_off,
   input  logic [WIDTH-1:0]         add_c,
   input  logic                     add_carry_out,
`ifdef WIDE_ADD_ACK_CHECK_EN
   input  logic                     add_ack,
   output logic                     err
`else
   input  logic                     add_ack
`endif
);
   localparam int TOTAL = WIDTH * CHUNKS;
   localparam int IW = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
   localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);
   state_t state, state_n;
   logic [IW-1:0] idx, idx_n;
   logic [TOTAL-1:0] a_r, b_r, a_n, b_n, sum_n;
   logic [WIDTH-1:0] add_a_n, add_b_n;
   logic cout_n, valid_n, cin_n, listen_n, on_n, ack_ok;
`ifdef WIDE_ADD_ACK_CHECK_EN
   logic err_n;
   assign ack_ok = add_ack;
`else
   logic unused_ack;
   assign unused_ack = add_ack;
   assign ack_ok = 1'b1;
`endif
   assign req_ready = state == IDLE;
   always_comb begin
      state_n = state;
      idx_n = idx;
      a_n = a_r;
      b_n = b_r;
      sum_n = resp_sum;
      cout_n = resp_cout;
      valid_n = resp_valid;
      add_a_n = add_a;
      add_b_n = add_b;
      cin_n = add_carry_in;
      listen_n = add_carry_listen;
      on_n = add_on_off;
`ifdef WIDE_ADD_ACK_CHECK_EN
      err_n = err;
`endif
      case (state)
         IDLE: if (req_valid) begin
            a_n = req_a;
            b_n = req_b;
            add_a_n = req_a[WIDTH-1:0];
            add_b_n = req_b[WIDTH-1:0];
            cin_n = req_cin;
            listen_n = 1'b1;
            on_n = 1'b1;
            idx_n = '0;
            state_n = DRIVE;
         end
         DRIVE: state_n = CAPTURE;
         CAPTURE: if (!ack_ok) begin
`ifdef WIDE_ADD_ACK_CHECK_EN
            err_n = 1'b1;
`endif
            on_n = 1'b0;
            listen_n = 1'b0;
            state_n = IDLE;
         end else begin
            sum_n[int'(idx)*WIDTH +: WIDTH] = add_c;
            if (idx != LAST) begin
               add_a_n = a_r[(int'(idx) + 1)*WIDTH +: WIDTH];
               add_b_n = b_r[(int'(idx) + 1)*WIDTH +: WIDTH];
               cin_n = add_carry_out;
               idx_n = idx + 1'b1;
               state_n = DRIVE;
            end else begin
               cout_n = add_carry_out;
               on_n = 1'b0;
               listen_n = 1'b0;
               valid_n = 1'b1;
               state_n = RESP;
            end
         end
         RESP: if (resp_ready) begin
            valid_n = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         idx <= '0;
         a_r <= '0;
         b_r <= '0;
         resp_sum <= '0;
         resp_cout <= 1'b0;
         resp_valid <= 1'b0;
         add_a <= '0;
         add_b <= '0;
         add_carry_in <= 1'b0;
         add_carry_listen <= 1'b0;
         add_on_off <= 1'b0;
`ifdef WIDE_ADD_ACK_CHECK_EN
         err <= 1'b0;
`endif
      end else begin
         state <= state_n;
         idx <= idx_n;
         a_r <= a_n;
         b_r <= b_n;
         resp_sum <= sum_n;
         resp_cout <= cout_n;
         resp_valid <= valid_n;
         add_a <= add_a_n;
         add_b <= add_b_n;
         add_carry_in <= cin_n;
         add_carry_listen <= listen_n;
         add_on_off <= on_n;
`ifdef WIDE_ADD_ACK_CHECK_EN
         err <= err_n;
`endif
      end
   end
endmodule
